input_array_bank_loader: RTL and testbench

Hardware loader that streams input-array words into `NUM_BANKS` replicated or striped RAM banks, replacing simulation-only back-door `$readmemh` preloading of each bank copy. It sits between a host/UART/DMA word stream and the datapath input-array RAM banks. It can optionally read the banks back to confirm that every replica agrees. The control unit starts it with `go_i` and releases the datapath on `done`.

---
 rtl/input_array_bank_loader.sv | 211 +++++++++++++++++++++
 tb/tb_input_array_bank_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_array_bank_loader.sv
// Streams input-array words into NUM_BANKS RAM bank copies (broadcast or striped), with an
// optional replica read-back compare built when LOADER_VERIFY_EN is defined.
module input_array_bank_loader #(
    parameter int unsigned NUM_BANKS = 6,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LEN_W     = $clog2(DEPTH * NUM_BANKS + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go_i,
    input  logic                        mode_i,
    input  logic [LEN_W-1:0]            len_i,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic [NUM_BANKS-1:0]        bank_we,
    output logic [$clog2(DEPTH)-1:0]    bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [7:0]                  err_bank,
    output logic [$clog2(DEPTH)-1:0]    err_addr,
    output logic [LEN_W-1:0]            word_count,
    output logic [DATA_W-1:0]           checksum
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [LEN_W-1:0] CAP_BCAST  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] CAP_STRIPE = LEN_W'(DEPTH * NUM_BANKS);

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StVerify, StDone} state_e;

    state_e                state_q, state_d;
    logic                  mode_q;
    logic [LEN_W-1:0]      len_q;
    logic [BANK_W-1:0]     stripe_bank_q;
    logic [ADDR_W-1:0]     stripe_addr_q;
    logic [LEN_W-1:0]      words_q;
    logic [DATA_W-1:0]     sum_q;
    logic [NUM_BANKS-1:0]  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  err_q;
    logic [7:0]            err_bank_q;
    logic                  done_q;

    logic start, len_bad, hs, last_word, verify_end;

    // A start coinciding with the done pulse is dropped; go_i must be re-asserted.
    assign start     = (state_q == StIdle) && go_i && !done_q;
    assign len_bad   = mode_i ? (len_i > CAP_STRIPE) : (len_i > CAP_BCAST);
    assign in_ready  = (state_q == StLoad);
    assign hs        = in_valid && in_ready;
    assign last_word = (words_q == len_q - LEN_W'(1));

`ifdef LOADER_VERIFY_EN
    logic [LEN_W-1:0]  rd_cnt_q;
    logic              cmp_valid_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              mismatch;
    logic [7:0]        mis_bank;

    // Scan downward so the lowest failing bank is the one reported.
    always_comb begin
        mismatch = 1'b0;
        mis_bank = 8'h00;
        for (int b = NUM_BANKS - 1; b >= 1; b--) begin
            if (bank_rdata[b*DATA_W +: DATA_W] != bank_rdata[0 +: DATA_W]) begin
                mismatch = 1'b1;
                mis_bank = 8'(b);
            end
        end
    end

    assign verify_end = cmp_valid_q && (mismatch || (LEN_W'(cmp_addr_q) == len_q - LEN_W'(1)));
    assign err_addr   = err_addr_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^bank_rdata;
    assign verify_end   = 1'b1;
    assign err_addr     = '0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len_i == '0 || len_bad) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (hs && last_word) state_d = StFlush;
            end
            StFlush: begin
`ifdef LOADER_VERIFY_EN
                state_d = mode_q ? StDone : StVerify;
`else
                state_d = StDone;
`endif
            end
            StVerify: begin
                if (verify_end) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q        <= 1'b0;
            len_q         <= '0;
            stripe_bank_q <= '0;
            stripe_addr_q <= '0;
            words_q       <= '0;
            sum_q         <= '0;
            we_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            err_bank_q    <= 8'h00;
            done_q        <= 1'b0;
`ifdef LOADER_VERIFY_EN
            rd_cnt_q      <= '0;
            cmp_valid_q   <= 1'b0;
            cmp_addr_q    <= '0;
            err_addr_q    <= '0;
`endif
        end else begin
            done_q <= (state_q == StDone);
            we_q   <= '0;
            if (start) begin
                err_q         <= len_bad;
                err_bank_q    <= len_bad ? 8'hFF : 8'h00;
                words_q       <= '0;
                sum_q         <= '0;
                mode_q        <= mode_i;
                len_q         <= len_i;
                stripe_bank_q <= '0;
                stripe_addr_q <= '0;
`ifdef LOADER_VERIFY_EN
                err_addr_q    <= '0;
`endif
            end
            if (hs) begin
                words_q <= words_q + LEN_W'(1);
                sum_q   <= sum_q ^ in_data;
                wdata_q <= in_data;
                if (mode_q) begin
                    we_q   <= NUM_BANKS'(1) << stripe_bank_q;
                    addr_q <= stripe_addr_q;
                    if (stripe_bank_q == BANK_W'(NUM_BANKS - 1)) begin
                        stripe_bank_q <= '0;
                        stripe_addr_q <= stripe_addr_q + ADDR_W'(1);
                    end else begin
                        stripe_bank_q <= stripe_bank_q + BANK_W'(1);
                    end
                end else begin
                    we_q   <= '1;
                    addr_q <= words_q[ADDR_W-1:0];
                end
            end
`ifdef LOADER_VERIFY_EN
            cmp_valid_q <= 1'b0;
            if (state_q == StFlush && !mode_q) begin
                addr_q   <= '0;
                rd_cnt_q <= '0;
            end
            if (state_q == StVerify) begin
                // Read data for the address issued this cycle is compared next cycle.
                if (rd_cnt_q < len_q) begin
                    rd_cnt_q    <= rd_cnt_q + LEN_W'(1);
                    addr_q      <= addr_q + ADDR_W'(1);
                    cmp_valid_q <= 1'b1;
                    cmp_addr_q  <= addr_q;
                end
                if (cmp_valid_q && mismatch && !err_q) begin
                    err_q      <= 1'b1;
                    err_bank_q <= mis_bank;
                    err_addr_q <= cmp_addr_q;
                end
            end
`endif
        end
    end

    assign bank_we    = we_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign err        = err_q;
    assign err_bank   = err_bank_q;
    assign word_count = words_q;
    assign checksum   = sum_q;

endmodule

// File: tb/tb_input_array_bank_loader.sv
// Scoreboard bench for input_array_bank_loader: expected bank writes are queued as words are
// accepted and checked as the loader emits them; behavioural RAM banks with fault injection.
module tb_input_array_bank_loader;

    localparam int NB = 6;
    localparam int DW = 64;
    localparam int DEPTH = 512;
    localparam int AW = 9;
    localparam int LW = 12;
`ifdef LOADER_VERIFY_EN
    localparam int VERIFY_ON = 1;
`else
    localparam int VERIFY_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [NB-1:0] bank_we;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_wdata;
    logic [NB*DW-1:0] bank_rdata = '0;
    logic          busy, done, err;
    logic [7:0]    err_bank;
    logic [AW-1:0] err_addr;
    logic [LW-1:0] word_count;
    logic [DW-1:0] checksum;

    input_array_bank_loader dut (
        .clk        (clk),
        .reset      (reset),
        .go_i       (go_i),
        .mode_i     (mode_i),
        .len_i      (len_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_bank   (err_bank),
        .err_addr   (err_addr),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural banks: 1-cycle read latency, optional corruption of bank 3 address 4.
    logic [DW-1:0] mem [NB][DEPTH];
    bit fault_en = 0;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_we[b]) mem[b][bank_addr] <= bank_wdata;
            bank_rdata[b*DW +: DW] <= (fault_en && b == 3 && bank_addr == 4) ?
                                      ~mem[b][bank_addr] : mem[b][bank_addr];
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [NB-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] exp_sum;
    int            exp_cnt;
    int            n_writes = 0;
    int            go_cyc;

    task automatic push_exp(input logic m, input int k, input logic [DW-1:0] d);
        wr_t e;
        e.we   = m ? NB'(1 << (k % NB)) : {NB{1'b1}};
        e.addr = m ? AW'(k / NB) : AW'(k);
        e.data = d;
        exp_q.push_back(e);
        exp_sum ^= d;
        exp_cnt++;
    endtask

    always @(negedge clk) begin
        if (reset && bank_we != '0) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'(bank_we), 64'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wr_we", 64'(bank_we), 64'(e.we));
                check_eq("wr_addr", 64'(bank_addr), 64'(e.addr));
                check_eq("wr_data", bank_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'h0);
        check_eq({tag, "_bank_we"}, 64'(bank_we), 64'h0);
        check_eq({tag, "_bank_addr"}, 64'(bank_addr), 64'h0);
        check_eq({tag, "_bank_wdata"}, bank_wdata, 64'h0);
        check_eq({tag, "_busy"}, 64'(busy), 64'h0);
        check_eq({tag, "_done"}, 64'(done), 64'h0);
        check_eq({tag, "_err"}, 64'(err), 64'h0);
        check_eq({tag, "_err_bank"}, 64'(err_bank), 64'h0);
        check_eq({tag, "_err_addr"}, 64'(err_addr), 64'h0);
        check_eq({tag, "_word_count"}, 64'(word_count), 64'h0);
        check_eq({tag, "_checksum"}, checksum, 64'h0);
    endtask

    task automatic start(input logic m, input int len);
        exp_sum = '0;
        exp_cnt = 0;
        mode_i  = m;
        len_i   = LW'(len);
        go_i    = 1'b1;
        go_cyc  = cyc;
        tick();
        go_i = 1'b0;
    endtask

    // Offers words base+k; toggle alternates in_valid; go_mid pulses a stray start mid-load.
    task automatic stream(input logic m, input int stop_after, input bit toggle,
                          input logic [DW-1:0] base, input bit go_mid);
        int k = 0;
        int guard = 0;
        bit ph = 1;
        while (k < stop_after && guard < 200) begin
            in_valid = toggle ? ph : 1'b1;
            in_data  = base + DW'(k);
            if (go_mid && guard == 2) begin
                go_i   = 1'b1;
                mode_i = 1'b1;
                len_i  = LW'(1);
            end else begin
                go_i = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                push_exp(m, k, in_data);
                k++;
            end
            tick();
            ph = !ph;
            guard++;
        end
        in_valid = 1'b0;
        go_i     = 1'b0;
        if (k < stop_after) check_eq("stream_timeout", 64'(k), 64'(stop_after));
    endtask

    // Leaves time at the negedge of the done cycle; lat is -1 on timeout.
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - go_cyc;
                break;
            end
        end
        if (lat < 0) check_eq("done_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w0;
        int dcount;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        tick();
        reset = 1'b1;
        tick();

        // Broadcast, words 1..9.
        start(1'b0, 9);
        check_eq("start_busy", 64'(busy), 64'h1);
        check_eq("start_in_ready", 64'(in_ready), 64'h1);
        stream(1'b0, 9, 1'b0, 64'd1, 1'b0);
        wait_done(60, lat);
        check_eq("bcast_lat", 64'(lat), 64'(12 + VERIFY_ON * 10));
        check_eq("bcast_err", 64'(err), 64'h0);
        check_eq("bcast_count", 64'(word_count), 64'd9);
        check_eq("bcast_sum", checksum, exp_sum);
        check_eq("bcast_sum_const", checksum, 64'd1);
        tick();
        check_eq("done_pulse", 64'(done), 64'h0);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 9; a++)
                check_eq("bcast_mem", mem[b][a], 64'(a + 1));

        // Striped, len 13.
        start(1'b1, 13);
        stream(1'b1, 13, 1'b0, 64'd100, 1'b0);
        wait_done(60, lat);
        check_eq("stripe_lat", 64'(lat), 64'd16);
        check_eq("stripe_err", 64'(err), 64'h0);
        check_eq("stripe_count", 64'(word_count), 64'd13);
        tick();
        check_eq("stripe_w12", mem[0][2], 64'd112);
        check_eq("stripe_w5", mem[5][0], 64'd105);

        // Length error: no writes, done two cycles after start.
        w0 = n_writes;
        start(1'b0, 513);
        wait_done(20, lat);
        check_eq("lenerr_lat", 64'(lat), 64'd2);
        check_eq("lenerr_err", 64'(err), 64'h1);
        check_eq("lenerr_bank", 64'(err_bank), 64'hFF);
        check_eq("lenerr_count", 64'(word_count), 64'h0);
        tick();
        check_eq("lenerr_writes", 64'(n_writes - w0), 64'h0);

        // Back-pressure with a stray start during LOAD.
        w0 = n_writes;
        start(1'b0, 4);
        stream(1'b0, 4, 1'b1, 64'd200, 1'b1);
        wait_done(60, lat);
        check_eq("bp_lat", 64'(lat), 64'(10 + VERIFY_ON * 5));
        check_eq("bp_err", 64'(err), 64'h0);
        check_eq("bp_count", 64'(word_count), 64'd4);
        check_eq("bp_sum", checksum, exp_sum);
        tick();
        check_eq("bp_writes", 64'(n_writes - w0), 64'd4);

`ifdef LOADER_VERIFY_EN
        // Verify catches a corrupted replica.
        fault_en = 1;
        start(1'b0, 9);
        stream(1'b0, 9, 1'b0, 64'd300, 1'b0);
        wait_done(60, lat);
        check_eq("vfy_lat", 64'(lat), 64'd18);
        check_eq("vfy_err", 64'(err), 64'h1);
        check_eq("vfy_bank", 64'(err_bank), 64'd3);
        check_eq("vfy_addr", 64'(err_addr), 64'd4);
        tick();
        fault_en = 0;
`endif

        // Reset mid-LOAD after three words.
        start(1'b0, 8);
        stream(1'b0, 3, 1'b0, 64'd400, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        exp_q.delete();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        tick();
        check_eq("midrst_no_done", 64'(dcount), 64'h0);
        start(1'b0, 2);
        stream(1'b0, 2, 1'b0, 64'd500, 1'b0);
        wait_done(60, lat);
        check_eq("post_err", 64'(err), 64'h0);
        check_eq("post_count", 64'(word_count), 64'd2);
        check_eq("post_sum", checksum, exp_sum);
        tick();
        tick();
        check_eq("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
